// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues single outstanding word reads to
// instruction memory and holds each fetched word until the core commits it.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            drop_reg, drop_next;
  logic [XLEN-1:0] inst_reg, inst_next;
  logic [XLEN-1:0] inst_pc_reg, inst_pc_next;

  logic            req_fire;
  logic [XLEN-1:0] flush_pc_aligned;
  logic [XLEN-1:0] redirect_aligned;
  logic [XLEN-1:0] pc_plus4;

  assign req_fire         = (state_reg == REQ) && imem_req_ready;
  assign flush_pc_aligned = {flush_pc[XLEN-1:2], 2'b00};
  assign redirect_aligned = {redirect_target[XLEN-1:2], 2'b00};
  assign pc_plus4         = pc_reg + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= BOOT;
      pc_reg      <= RESET_PC[XLEN-1:0];
      drop_reg    <= 1'b0;
      inst_reg    <= '0;
      inst_pc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      drop_reg    <= drop_next;
      inst_reg    <= inst_next;
      inst_pc_reg <= inst_pc_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    drop_next    = drop_reg;
    inst_next    = inst_reg;
    inst_pc_next = inst_pc_reg;

    // Flush wins over everything; an already-issued request must still be drained.
    if (flush) begin
      pc_next = flush_pc_aligned;
      unique case (state_reg)
        BOOT, HOLD: state_next = REQ;
        REQ: begin
          if (req_fire) begin
            state_next = WAIT;
            drop_next  = 1'b1;
          end else begin
            state_next = REQ;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            state_next = REQ;
            drop_next  = 1'b0;
          end else begin
            drop_next  = 1'b1;
          end
        end
        default: state_next = BOOT;
      endcase
    end else begin
      unique case (state_reg)
        BOOT: state_next = REQ;
        REQ: begin
          if (req_fire) state_next = WAIT;
        end
        WAIT: begin
          if (imem_resp_valid) begin
            if (drop_reg) begin
              drop_next  = 1'b0;
              state_next = REQ;
            end else begin
              inst_next    = imem_resp_data;
              inst_pc_next = pc_reg;
              state_next   = HOLD;
            end
          end
        end
        HOLD: begin
          if (inst_ready) begin
            pc_next    = redirect ? redirect_aligned : pc_plus4;
            state_next = REQ;
          end
        end
        default: state_next = BOOT;
      endcase
    end
  end

  assign imem_req_valid = (state_reg == REQ);
  assign imem_req_addr  = pc_reg;
  assign inst_valid     = (state_reg == HOLD);
  assign inst           = inst_reg;
  assign inst_pc        = inst_pc_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        flush;
  logic [31:0] flush_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h8000_0000), .XLEN(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .flush           (flush),
    .flush_pc        (flush_pc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered on a falling edge with the DUT in REQ; leaves it in HOLD.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check_eq({tag, " req_valid"}, 32'(imem_req_valid), 32'd1);
    check_eq({tag, " req_addr"}, imem_req_addr, addr);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    check_eq({tag, " wait_req_valid"}, 32'(imem_req_valid), 32'd0);
    check_eq({tag, " wait_inst_valid"}, 32'(inst_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    check_eq({tag, " inst_valid"}, 32'(inst_valid), 32'd1);
    check_eq({tag, " inst"}, inst, data);
    check_eq({tag, " inst_pc"}, inst_pc, addr);
    $display("fetch %s addr=0x%08h inst=0x%08h", tag, imem_req_addr, inst);
  endtask

  // Entered in HOLD; commits and checks the back-to-back request address.
  task automatic commit(input string tag, input logic rd, input logic [31:0] tgt,
                        input logic [31:0] next_addr);
    inst_ready      = 1'b1;
    redirect        = rd;
    redirect_target = tgt;
    @(negedge clk);
    inst_ready      = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    check_eq({tag, " next_req_valid"}, 32'(imem_req_valid), 32'd1);
    check_eq({tag, " next_addr"}, imem_req_addr, next_addr);
    check_eq({tag, " inst_valid_drop"}, 32'(inst_valid), 32'd0);
    $display("commit %s redirect=%0d next_addr=0x%08h", tag, rd, imem_req_addr);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    flush = 1'b0; flush_pc = 32'h0;

    // T1: reset state, then first fetch
    repeat (3) @(negedge clk);
    check_eq("rst req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst inst", inst, 32'h0);
    check_eq("rst inst_pc", inst_pc, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    fetch("T1", 32'h8000_0000, 32'h0000_0013);
    commit("T1", 1'b0, 32'h0, 32'h8000_0004);

    // T3: redirect target is word-aligned
    fetch("T3", 32'h8000_0004, 32'h0010_0093);
    commit("T3", 1'b1, 32'h8000_0103, 32'h8000_0100);

    // T2: flush in REQ without accept, then pc+4 wraps
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    flush = 1'b0; flush_pc = 32'h0;
    fetch("T2", 32'hFFFF_FFFC, 32'h1111_1111);
    commit("T2", 1'b0, 32'h0, 32'h0000_0000);

    // T4: memory stalls, then core stalls with a spurious response in HOLD
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("T4 stall req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("T4 stall addr", imem_req_addr, 32'h0);
    end
    fetch("T4", 32'h0000_0000, 32'h2222_2222);
    for (int i = 0; i < 4; i++) begin
      imem_resp_valid = (i == 1);
      imem_resp_data  = 32'hBAD0_0BAD;
      @(negedge clk);
      check_eq("T4 hold inst_valid", 32'(inst_valid), 32'd1);
      check_eq("T4 hold inst", inst, 32'h2222_2222);
      check_eq("T4 hold inst_pc", inst_pc, 32'h0);
      check_eq("T4 hold req_valid", 32'(imem_req_valid), 32'd0);
    end
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    commit("T4", 1'b0, 32'h0, 32'h0000_0004);

    // T5: flush in WAIT, stale response discarded
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    flush = 1'b1; flush_pc = 32'h8000_1000;
    @(negedge clk);
    flush = 1'b0; flush_pc = 32'h0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    check_eq("T5 drop req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    check_eq("T5 stale inst_valid", 32'(inst_valid), 32'd0);
    fetch("T5", 32'h8000_1000, 32'h3333_3333);
    commit("T5", 1'b0, 32'h0, 32'h8000_1004);

    // T6a: reset mid-WAIT, late response ignored
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("T6 async req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("T6 async inst", inst, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hCAFE_F00D;
    @(negedge clk);
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    check_eq("T6 late inst_valid", 32'(inst_valid), 32'd0);
    fetch("T6", 32'h8000_0000, 32'h4444_4444);

    // T6b: flush beats commit+redirect
    inst_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h1234_5678;
    flush = 1'b1; flush_pc = 32'h8000_2002;
    @(negedge clk);
    inst_ready = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    flush = 1'b0; flush_pc = 32'h0;
    check_eq("T6 flush req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("T6 flush addr", imem_req_addr, 32'h8000_2000);
    check_eq("T6 flush inst_valid", 32'(inst_valid), 32'd0);
    $display("flush T6 next_addr=0x%08h", imem_req_addr);

    // Flush coinciding with request accept: response still drained
    imem_req_ready = 1'b1; flush = 1'b1; flush_pc = 32'h8000_3000;
    @(negedge clk);
    imem_req_ready = 1'b0; flush = 1'b0; flush_pc = 32'h0;
    check_eq("T7 accept req_valid", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1; imem_resp_data = 32'h5555_5555;
    @(negedge clk);
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    check_eq("T7 dropped inst_valid", 32'(inst_valid), 32'd0);
    fetch("T7", 32'h8000_3000, 32'h6666_6666);
    commit("T7", 1'b0, 32'h0, 32'h8000_3004);

    // Flush coinciding with response in WAIT
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    flush = 1'b1; flush_pc = 32'h8000_4000;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h7777_7777;
    @(negedge clk);
    flush = 1'b0; flush_pc = 32'h0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    check_eq("T8 req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("T8 addr", imem_req_addr, 32'h8000_4000);
    check_eq("T8 inst_valid", 32'(inst_valid), 32'd0);
    fetch("T8", 32'h8000_4000, 32'h8888_8888);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
